// File: rtl/k423_br_pkg.sv
// k423_br_pkg: shared types and constants for the EX-stage redirect controller.
//   state_e    : redirect FSM states
//   redirect_t : redirect request bundle driven towards IF
package k423_br_pkg;

   localparam int K423_ADDR_W = 32;
   localparam int FLUSH_CYC_W = 3;

   typedef enum logic [1:0] {
      IDLE,
      REDIR,
      DRAIN
   } state_e;

   typedef struct packed {
      logic                   vld;
      logic [K423_ADDR_W-1:0] pc;
   } redirect_t;

endpackage

// File: rtl/k423_perf_cnt.sv
// k423_perf_cnt: CNT_W-bit enable-increment event counter, wraps at 2^CNT_W.
//   clk_i, rst_n_i : clock, async active-low reset
//   en_i           : count this cycle
//   cnt_o          : current count
module k423_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb cnt_d = en_i ? cnt_q + 1'b1 : cnt_q;

   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) cnt_q <= '0;
      else          cnt_q <= cnt_d;

   assign cnt_o = cnt_q;

endmodule

// File: rtl/utils_adder32.sv
// utils_adder32: plain W-bit adder with carry-in, result wraps modulo 2^W.
//   a_i, b_i : operands
//   cin_i    : carry in
//   sum_o    : a_i + b_i + cin_i (truncated to W bits)
module utils_adder32 #(
   parameter int W = 32
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         cin_i,
   output logic [W-1:0] sum_o
);

   assign sum_o = a_i + b_i + {{(W-1){1'b0}}, cin_i};

endmodule

// File: rtl/k423_ex_redirect_ctrl.sv
// k423_ex_redirect_ctrl: EX-stage branch resolution -> front-end redirect sequencer.
//   ex_*_i / bju_*_i / pred_*_i : EX instruction, BJU outcome, IF prediction
//   trap_vld_i / trap_pc_i      : trap/CSR redirect request (pulse) and vector
//   redirect_*                  : redirect request to IF, held until redirect_rdy_i
//   flush_o / ex_stall_o        : kill younger stages / hold EX
//   misalign_o                  : registered pulse on taken target with bit[1] set
//   upd_*_o                     : registered predictor update, one pulse per resolved BJU
//   br_cnt_o / mispred_cnt_o    : resolved-BJU and mispredict counters
module k423_ex_redirect_ctrl
   import k423_br_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int FLUSH_CYC = 1,
   parameter int CNT_W     = 32
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              ex_vld_i,
   input  logic              ex_is_bju_i,
   input  logic              ex_is_jal_i,
   input  logic [ADDR_W-1:0] ex_pc_i,
   input  logic              bju_br_tkn_i,
   input  logic [ADDR_W-1:0] bju_br_pc_i,
   input  logic              pred_tkn_i,
   input  logic [ADDR_W-1:0] pred_pc_i,
   input  logic              trap_vld_i,
   input  logic [ADDR_W-1:0] trap_pc_i,
   output logic              redirect_vld_o,
   output logic [ADDR_W-1:0] redirect_pc_o,
   input  logic              redirect_rdy_i,
   output logic              flush_o,
   output logic              ex_stall_o,
   output logic              misalign_o,
   output logic              upd_vld_o,
   output logic [ADDR_W-1:0] upd_pc_o,
   output logic [ADDR_W-1:0] upd_tgt_o,
   output logic              upd_tkn_o,
   output logic              upd_jal_o,
   output logic [CNT_W-1:0]  br_cnt_o,
   output logic [CNT_W-1:0]  mispred_cnt_o
);

   state_e                 state_q, state_d;
   logic [ADDR_W-1:0]      tgt_q, tgt_d;
   logic [FLUSH_CYC_W-1:0] cnt_q, cnt_d;
   logic                   mal_q, mal_d;
   logic                   upd_vld_q, upd_vld_d, upd_tkn_q, upd_tkn_d, upd_jal_q, upd_jal_d;
   logic [ADDR_W-1:0]      upd_pc_q, upd_pc_d, upd_tgt_q, upd_tgt_d;
   logic [ADDR_W-1:0]      fall;
   logic                   busy, res, mis, mal;
   redirect_t              redir;

   utils_adder32 #(.W(ADDR_W)) u_fall (
      .a_i   (ex_pc_i),
      .b_i   (ADDR_W'(4)),
      .cin_i (1'b0),
      .sum_o (fall)
   );

   // Resolution is gated by the stall so nothing resolves while a redirect is in flight.
   assign busy = (state_q != IDLE);
   assign res  = ex_vld_i & ex_is_bju_i & ~busy;
   assign mis  = res & ((bju_br_tkn_i != pred_tkn_i) | (bju_br_tkn_i & (bju_br_pc_i != pred_pc_i)));
   assign mal  = res & bju_br_tkn_i & bju_br_pc_i[1];

   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) state_q <= IDLE;
      else          state_q <= state_d;

   // A trap overrides everything, in every state, including a same-cycle IF handshake.
   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;
      if (trap_vld_i) begin
         state_d = REDIR;
         tgt_d   = trap_pc_i;
      end else begin
         case (state_q)
            IDLE:
               if (mis & ~mal) begin
                  state_d = REDIR;
                  tgt_d   = bju_br_tkn_i ? bju_br_pc_i : fall;
               end
            REDIR:
               if (redirect_rdy_i) begin
                  state_d = (FLUSH_CYC == 0) ? IDLE : DRAIN;
                  cnt_d   = FLUSH_CYC_W'(FLUSH_CYC);
               end
            DRAIN: begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == FLUSH_CYC_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      redir.vld  = (state_q == REDIR);
      redir.pc   = redir.vld ? tgt_q : '0;
      ex_stall_o = busy;
      flush_o    = busy | trap_vld_i | (mis & ~mal);
   end

   assign redirect_vld_o = redir.vld;
   assign redirect_pc_o  = redir.pc;

   // Predictor update fields hold their last value between pulses.
   always_comb begin
      mal_d     = mal;
      upd_vld_d = res;
      upd_pc_d  = res ? ex_pc_i      : upd_pc_q;
      upd_tgt_d = res ? bju_br_pc_i  : upd_tgt_q;
      upd_tkn_d = res ? bju_br_tkn_i : upd_tkn_q;
      upd_jal_d = res ? ex_is_jal_i  : upd_jal_q;
   end

   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         tgt_q     <= '0;
         cnt_q     <= '0;
         mal_q     <= 1'b0;
         upd_vld_q <= 1'b0;
         upd_pc_q  <= '0;
         upd_tgt_q <= '0;
         upd_tkn_q <= 1'b0;
         upd_jal_q <= 1'b0;
      end else begin
         tgt_q     <= tgt_d;
         cnt_q     <= cnt_d;
         mal_q     <= mal_d;
         upd_vld_q <= upd_vld_d;
         upd_pc_q  <= upd_pc_d;
         upd_tgt_q <= upd_tgt_d;
         upd_tkn_q <= upd_tkn_d;
         upd_jal_q <= upd_jal_d;
      end

   assign misalign_o = mal_q;
   assign upd_vld_o  = upd_vld_q;
   assign upd_pc_o   = upd_pc_q;
   assign upd_tgt_o  = upd_tgt_q;
   assign upd_tkn_o  = upd_tkn_q;
   assign upd_jal_o  = upd_jal_q;

   k423_perf_cnt #(.CNT_W(CNT_W)) u_br_cnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .en_i    (res),
      .cnt_o   (br_cnt_o)
   );

   k423_perf_cnt #(.CNT_W(CNT_W)) u_mis_cnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .en_i    (mis),
      .cnt_o   (mispred_cnt_o)
   );

endmodule

// File: tb/tb_k423_ex_redirect_ctrl.sv
// tb_k423_ex_redirect_ctrl: directed + random bench against a behavioural redirect model.
module tb_k423_ex_redirect_ctrl;

   localparam int AW = 32;
   localparam int CW = 32;
   localparam int FC = 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ex_vld, ex_bju, ex_jal, tkn, ptkn, trap, rdy;
   logic [AW-1:0] ex_pc, br_pc, pred_pc, trap_pc;
   logic          rvld, flush, stall, misal, uvld, utkn, ujal;
   logic [AW-1:0] rpc, upc, utgt;
   logic [CW-1:0] brc, misc;

   always #5 clk = ~clk;

   k423_ex_redirect_ctrl #(.ADDR_W(AW), .FLUSH_CYC(FC), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .ex_vld_i(ex_vld), .ex_is_bju_i(ex_bju), .ex_is_jal_i(ex_jal), .ex_pc_i(ex_pc),
      .bju_br_tkn_i(tkn), .bju_br_pc_i(br_pc), .pred_tkn_i(ptkn), .pred_pc_i(pred_pc),
      .trap_vld_i(trap), .trap_pc_i(trap_pc),
      .redirect_vld_o(rvld), .redirect_pc_o(rpc), .redirect_rdy_i(rdy),
      .flush_o(flush), .ex_stall_o(stall), .misalign_o(misal),
      .upd_vld_o(uvld), .upd_pc_o(upc), .upd_tgt_o(utgt), .upd_tkn_o(utkn), .upd_jal_o(ujal),
      .br_cnt_o(brc), .mispred_cnt_o(misc)
   );

   int vec = 0;
   int errs = 0;

   // Behavioural model: a pending redirect plus a count of remaining drain cycles.
   bit            m_pend;
   logic [AW-1:0] m_tgt;
   int            m_drain;
   bit            m_mal, m_uvld, m_utkn, m_ujal;
   logic [AW-1:0] m_upc, m_utgt;
   logic [CW-1:0] m_br, m_mis;

   task automatic mreset;
      m_pend = 0; m_tgt = '0; m_drain = 0; m_mal = 0; m_uvld = 0; m_utkn = 0; m_ujal = 0;
      m_upc = '0; m_utgt = '0; m_br = '0; m_mis = '0;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec++;
      assert (obs === exp)
      else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle;
      ex_vld = 0; ex_bju = 0; ex_jal = 0; tkn = 0; ptkn = 0; trap = 0; rdy = 0;
      ex_pc = '0; br_pc = '0; pred_pc = '0; trap_pc = '0;
   endtask

   task automatic br(input logic [AW-1:0] pc, input logic t, input logic [AW-1:0] tgt,
                     input logic pt, input logic [AW-1:0] pp, input logic j);
      idle;
      ex_vld = 1; ex_bju = 1; ex_pc = pc; tkn = t; br_pc = tgt; ptkn = pt; pred_pc = pp; ex_jal = j;
   endtask

   // Called 1 time unit after a rising edge with inputs already applied.
   task automatic cycle;
      bit busy, res, mis, mal;
      #4;
      busy = m_pend || (m_drain != 0);
      res  = ex_vld && ex_bju && !busy;
      mis  = res && ((tkn != ptkn) || (tkn && br_pc != pred_pc));
      mal  = res && tkn && br_pc[1];
      chk("flush", flush, busy || trap || (mis && !mal));
      chk("stall", stall, busy);
      chk("redirect_vld", rvld, m_pend);
      chk("redirect_pc", rpc, m_pend ? m_tgt : '0);
      chk("misalign", misal, m_mal);
      chk("upd_vld", uvld, m_uvld);
      if (m_uvld) begin
         chk("upd_pc", upc, m_upc);
         chk("upd_tgt", utgt, m_utgt);
         chk("upd_tkn", utkn, m_utkn);
         chk("upd_jal", ujal, m_ujal);
      end
      chk("br_cnt", brc, m_br);
      chk("mispred_cnt", misc, m_mis);
      @(posedge clk);
      m_mal  = mal;
      m_uvld = res;
      if (res) begin
         m_upc = ex_pc; m_utgt = br_pc; m_utkn = tkn; m_ujal = ex_jal;
      end
      m_br  = m_br + (res ? 1 : 0);
      m_mis = m_mis + (mis ? 1 : 0);
      if (trap) begin
         m_pend = 1; m_tgt = trap_pc; m_drain = 0;
      end else if (m_pend) begin
         if (rdy) begin
            m_pend = 0; m_drain = FC;
         end
      end else if (m_drain != 0) begin
         m_drain--;
      end else if (mis && !mal) begin
         m_pend = 1; m_tgt = tkn ? br_pc : ex_pc + 32'd4;
      end
      #1;
   endtask

   initial begin
      idle;
      mreset;
      rst_n = 0;
      #12;
      chk("rst_vld", rvld, 0);
      chk("rst_pc", rpc, 0);
      chk("rst_flush", flush, 0);
      chk("rst_stall", stall, 0);
      chk("rst_upd", uvld, 0);
      chk("rst_brc", brc, 0);
      chk("rst_misc", misc, 0);
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;

      // 1: correctly predicted taken BEQ
      br(32'h100, 1, 32'h140, 1, 32'h140, 0); cycle; idle;
      chk("t1_upd_vld", uvld, 1);
      chk("t1_br_cnt", brc, 1);
      chk("t1_no_redirect", rvld, 0);
      cycle;

      // 2: not-taken BNE predicted taken, IF stalls 3 cycles
      br(32'h200, 0, 32'h260, 1, 32'h300, 0); cycle; idle;
      chk("t2_vld", rvld, 1);
      chk("t2_pc", rpc, 32'h204);
      repeat (3) cycle;
      rdy = 1; cycle; rdy = 0;
      chk("t2_drop", rvld, 0);
      chk("t2_drain", stall, 1);
      chk("t2_mis_cnt", misc, 1);
      cycle;
      chk("t2_idle", stall, 0);

      // 3: misaligned JALR target
      br(32'h300, 1, 32'h80000002, 0, 32'h0, 1); cycle; idle;
      chk("t3_misalign", misal, 1);
      chk("t3_no_redirect", rvld, 0);
      chk("t3_upd_jal", ujal, 1);
      cycle;

      // 4: trap replaces pending target, same-cycle handshake ignored
      br(32'h200, 0, 32'h0, 1, 32'h300, 0); cycle; idle;
      chk("t4_pre_pc", rpc, 32'h204);
      trap = 1; trap_pc = 32'h1000; rdy = 1; cycle; idle;
      chk("t4_vld", rvld, 1);
      chk("t4_pc", rpc, 32'h1000);
      rdy = 1; cycle; rdy = 0; cycle;

      // 5: fall-through wraps
      br(32'hFFFFFFFC, 0, 32'h0, 1, 32'h10, 0); cycle; idle;
      chk("t5_vld", rvld, 1);
      chk("t5_pc", rpc, 32'h0);
      rdy = 1; cycle; rdy = 0; cycle;

      // 6: async reset mid-REDIR
      br(32'h200, 0, 32'h0, 1, 32'h300, 0); cycle; idle;
      #2 rst_n = 0;
      #1;
      chk("t6_vld", rvld, 0);
      chk("t6_flush", flush, 0);
      chk("t6_stall", stall, 0);
      mreset;
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;
      cycle;

      // random traffic
      repeat (3000) begin
         ex_vld  = $urandom_range(0, 3) != 0;
         ex_bju  = $urandom_range(0, 2) != 0;
         ex_jal  = 1'($urandom);
         ex_pc   = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
         tkn     = 1'($urandom);
         br_pc   = 32'h1000 + 32'($urandom_range(0, 3) << 2);
         if ($urandom_range(0, 7) == 0) br_pc[1] = 1'b1;
         ptkn    = ($urandom_range(0, 9) < 7) ? tkn : ~tkn;
         pred_pc = ($urandom_range(0, 9) < 7) ? br_pc : ($urandom & 32'hFFFFFFFC);
         trap    = $urandom_range(0, 19) == 0;
         trap_pc = $urandom & 32'hFFFFFFFC;
         rdy     = 1'($urandom);
         cycle;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
